muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide engine for the EX stage. It replaces
//  the fixed 32-bit mult/div path with one engine offering a start/done handshake,
//  a configurable multiply latency, an iterative radix-2 divider and flush cancel.
//  The EX stage holds the pipeline while busy is 1 and writes HI/LO when done pulses.
// PARAMETERS
//  WIDTH    32  operand width; hi_out and lo_out are each WIDTH bits
//  MUL_LAT  5   cycles from start accept to multiply done; legal range 1..15
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  flush        in   1      cancel any operation in flight (exception/branch flush)
//  start        in   1      request; sampled only while busy=0
//  op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                           100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
//  src_a        in   WIDTH  multiplicand / dividend
//  src_b        in   WIDTH  multiplier / divisor
//  hi_in        in   WIDTH  current HI (accumulate ops only)
//  lo_in        in   WIDTH  current LO (accumulate ops only)
//  busy         out  1      operation in flight; stall request to hazard unit
//  done         out  1      one-cycle pulse: hi_out/lo_out valid, write HI/LO
//  hi_out       out  WIDTH  product[2W-1:W] or remainder
//  lo_out       out  WIDTH  product[W-1:0] or quotient
//  div_by_zero  out  1      qualifies done: last divide had src_b==0
// BEHAVIOUR
//  - Reset (async): state=IDLE. busy, done, div_by_zero, hi_out and lo_out are all 0.
//  - FSM states: IDLE, MUL, DIV, FIX, DONE. busy = (state != IDLE).
//  - IDLE: start & ~flush latches op, src_a, src_b, hi_in and lo_in.
//    MULx/MADDx/MSUBx go to MUL. DIVx goes to DIV.
//  - MUL: a 4-bit counter runs MUL_LAT-1 cycles, then the FSM goes to DONE.
//    done is asserted exactly MUL_LAT cycles after the accept edge.
//  - Signed ops (op[0]=0): operands are sign-extended to 2W. Unsigned ops: zero-extended.
//  - DIV: restoring division on operand magnitudes, one quotient bit per cycle,
//    WIDTH cycles, then FIX.
//  - FIX: applies signs. The quotient is negated if the operand signs differ. The
//    remainder takes the sign of the dividend. Then DONE.
//    Divide done is asserted exactly WIDTH+2 cycles after accept.
//  - Signed overflow MIN/-1: quotient = MIN, remainder = 0 (two's-complement wrap).
//  - Divide by zero: same latency. lo_out = all ones, hi_out = src_a,
//    div_by_zero = 1. No trap is raised.
//  - DONE: lasts one cycle. done=1 and hi_out/lo_out are updated on entry.
//    The next state is IDLE, so busy falls on the same edge that done falls.
//  - hi_out, lo_out and div_by_zero hold until the next DONE.
//    div_by_zero is cleared on a multiply DONE.
//  - start while busy=1 is ignored; there is no queueing.
//  - Back-to-back: start may be accepted in the first IDLE cycle after DONE.
//  - flush: state goes to IDLE on the next edge from any state, with no done pulse.
//    Outputs keep their previous values. A start coincident with flush is ignored.
//    A flush in the DONE cycle still lets that done pulse through; it is already
//    registered.
//  - Operand registers are not observable while busy. src_a/src_b may change after
//    accept without affecting the result.
// CONFIGURATION
//  - MULDIV_ACC_EN defined:
//    MADD/MADDU: result = {hi_in,lo_in} + product, computed modulo 2^(2W).
//    MSUB/MSUBU: result = {hi_in,lo_in} - product, computed modulo 2^(2W).
//    Accumulation adds one cycle, so latency is MUL_LAT+1.
//  - MULDIV_ACC_EN undefined: op codes 1xx behave exactly as 0xx (plain MULT/MULTU).
//    hi_in and lo_in are unused.
// TESTING
//  1. WIDTH=32, MULT with src_a=0xFFFFFFFE (-2), src_b=3 -> done at cycle 5;
//     hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//     The same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
//  2. DIV with src_a=-7, src_b=2 -> done at cycle 34; lo=0xFFFFFFFD (-3),
//     hi=0xFFFFFFFF (-1).
//     DIVU with src_a=100, src_b=7 -> lo=14, hi=2.
//  3. DIV with src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0,
//     div_by_zero=0.
//     DIVU with src_a=5, src_b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
//  4. Start a DIV, assert flush at cycle 10 -> busy=0 next cycle, no done pulse,
//     hi/lo unchanged.
//     A new MULT started the cycle after the flush completes normally.
//  5. Pulse start every cycle during a MULT -> exactly one done.
//     A second start in the cycle after DONE is accepted.
//     Assert rst mid-DIV -> all outputs 0 immediately (async).
//  6. With MULDIV_ACC_EN: hi_in=0, lo_in=10, MSUB 3*4 -> done at cycle 6;
//     hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     Without the macro, the same op -> hi=0, lo=12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for EX: fixed-latency multiply, radix-2 divide.
// Define MULDIV_ACC_EN to enable MADD/MSUB accumulation into {hi_in,lo_in}.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] MUL_LIM = 4'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t state, state_n;

  logic [3:0]       mcnt;
  logic [CW-1:0]    dcnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;

  logic             sgn, a_neg, b_neg, accept, enter_done;
  logic [3:0]       mul_lim;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   rem_sh, diff;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign accept = (state == IDLE) & start & ~flush;
  assign sgn    = ~op_q[0];

  assign ext_a = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

`ifdef MULDIV_ACC_EN
  // Accumulate ops spend one extra cycle in MUL for the add/subtract.
  assign mul_lim = op_q[2] ? MUL_LIM + 4'd1 : MUL_LIM;
  always_comb begin
    mul_res = prod;
    unique case (op_q[2:1])
      2'b10:   mul_res = {hi_q, lo_q} + prod;
      2'b11:   mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
  end
`else
  assign mul_lim = MUL_LIM;
  assign mul_res = prod;
`endif

  assign a_neg = sgn & a_q[WIDTH-1];
  assign b_neg = sgn & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, b_mag};

  assign q_fix = (a_neg ^ b_neg) ? -quo_q : quo_q;
  assign r_fix = a_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = (op[2:1] == 2'b01) ? DIV : MUL;
      MUL:  if (mcnt == mul_lim) state_n = DONE;
      DIV:  if (dcnt == DIV_LAST) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  assign enter_done = (state_n == DONE) & (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt        <= '0;
      dcnt        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= src_a;
        b_q  <= src_b;
        hi_q <= hi_in;
        lo_q <= lo_in;
        mcnt <= '0;
        dcnt <= '0;
      end
      if (state == MUL) mcnt <= mcnt + 4'd1;
      if (state == DIV) begin
        dcnt <= dcnt + CW'(1);
        // First DIV cycle loads magnitudes; the next WIDTH cycles each retire a bit.
        if (dcnt == '0) begin
          rem_q <= '0;
          quo_q <= a_mag;
        end else if (!diff[WIDTH]) begin
          rem_q <= diff;
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= rem_sh;
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      if (enter_done && state == MUL) begin
        hi_out      <= mul_res[2*WIDTH-1:WIDTH];
        lo_out      <= mul_res[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
      if (enter_done && state == FIX) begin
        if (b_q == '0) begin
          hi_out      <= a_q;
          lo_out      <= '1;
          div_by_zero <= 1'b1;
        end else begin
          hi_out      <= r_fix;
          lo_out      <= q_fix;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush/back-to-back/reset sequences.
// Expectations follow MULDIV_ACC_EN when it is defined for the build.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int ML = 5;
`ifdef MULDIV_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] src_a = '0, src_b = '0, hi_in = '0, lo_in = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi_out, lo_out;

  int n_run = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_in(hi_in), .lo_in(lo_in),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic [W-1:0] e_hi, e_lo;
    logic         e_dbz;
    int           e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op from an IDLE cycle; report edges from accept to done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi,
                        input logic [W-1:0] lo, output int lat);
    op = o; src_a = a; src_b = b; hi_in = hi; lo_in = lo;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, dcount;
    logic [W-1:0] h0, l0;

    vecs[0]  = '{"mult_neg",  3'b000, 32'hFFFFFFFE, 32'd3, 0, 0,
                 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, ML};
    vecs[1]  = '{"multu",     3'b001, 32'hFFFFFFFE, 32'd3, 0, 0,
                 32'h00000002, 32'hFFFFFFFA, 1'b0, ML};
    vecs[2]  = '{"div_neg",   3'b010, -32'sd7, 32'd2, 0, 0,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 2};
    vecs[3]  = '{"divu",      3'b011, 32'd100, 32'd7, 0, 0,
                 32'd2, 32'd14, 1'b0, W + 2};
    vecs[4]  = '{"div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0,
                 32'd0, 32'h80000000, 1'b0, W + 2};
    vecs[5]  = '{"divu_zero", 3'b011, 32'd5, 32'd0, 0, 0,
                 32'd5, 32'hFFFFFFFF, 1'b1, W + 2};
    vecs[6]  = '{"mult_clr",  3'b000, 32'd7, 32'hFFFFFFFF, 0, 0,
                 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, ML};
    vecs[7]  = '{"div_negb",  3'b010, 32'd7, -32'sd2, 0, 0,
                 32'd1, 32'hFFFFFFFD, 1'b0, W + 2};
    vecs[8]  = '{"msub",      3'b110, 32'd3, 32'd4, 32'd0, 32'd10,
                 ACC ? 32'hFFFFFFFF : 32'd0,
                 ACC ? 32'hFFFFFFFE : 32'd12, 1'b0, ACC ? ML + 1 : ML};
    vecs[9]  = '{"maddu",     3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1,
                 32'hFFFFFFFE, ACC ? 32'h00000002 : 32'h00000001, 1'b0,
                 ACC ? ML + 1 : ML};
    vecs[10] = '{"div_zero",  3'b010, -32'sd5, 32'd0, 0, 0,
                 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, W + 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, lat);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].e_lat));
      chk({vecs[i].name, "_hi"}, 64'(hi_out), 64'(vecs[i].e_hi));
      chk({vecs[i].name, "_lo"}, 64'(lo_out), 64'(vecs[i].e_lo));
      chk({vecs[i].name, "_dbz"}, 64'(div_by_zero), 64'(vecs[i].e_dbz));
      @(posedge clk); #1;
      chk({vecs[i].name, "_idle"}, {62'd0, busy, done}, 64'd0);
    end

    // Flush a DIV in flight, then start a MULT right away.
    h0 = hi_out; l0 = lo_out;
    op = 3'b010; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hilo", {hi_out, lo_out}, {h0, l0});
    run_op(3'b000, 32'd5, 32'd6, 0, 0, lat);
    chk("post_flush_lat", 64'(lat), 64'(ML));
    chk("post_flush_lo", 64'(lo_out), 64'd30);
    @(posedge clk); #1;

    // Start held high throughout a MULT: one done, then re-accept after DONE.
    op = 3'b000; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    src_a = 32'd9; src_b = 32'd9;
    dcount = 0;
    for (int k = 1; k <= ML + 1; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (k == ML) chk("hold_lo", 64'(lo_out), 64'd6);
    end
    chk("hold_one_done", 64'(dcount), 64'd1);
    chk("hold_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'(ML));
    chk("b2b_lo", 64'(lo_out), 64'd81);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a DIV.
    op = 3'b011; src_a = 32'd50; src_b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hilo", {hi_out, lo_out}, 64'd0);
    chk("arst_done", {62'd0, done, div_by_zero}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
